// File: rtl/uart_prog_rx.sv
// UART programming receiver: deserialises 8N1 bytes, parses a target/count header and writes
// 32-bit little-endian words to the instruction or data memory upgrade port.
module uart_prog_rx #(
   parameter int unsigned CLK_FREQ = 23_000_000,
   parameter int unsigned BAUD     = 115_200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        rx,
   output logic        upg_wen_o,
   output logic [14:0] upg_adr_o,
   output logic [31:0] upg_dat_o,
   output logic        upg_done_o,
   output logic        err_o
);

   localparam int unsigned DIV    = CLK_FREQ / (BAUD * 16);
   localparam int unsigned DivW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);

   typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
   typedef enum logic [2:0] {SHdr0, SHdr1, SHdr2, SData, SWrite, SDone} sess_state_e;

   logic            rx_s1_q, rx_s2_q, rx_prev_q;
   logic [DivW-1:0] div_q, div_d;
   rx_state_e       rx_st_q, rx_st_d;
   logic [3:0]      tcnt_q, tcnt_d;
   logic [2:0]      bcnt_q, bcnt_d;
   logic [7:0]      shift_q, shift_d;

   sess_state_e     sess_q, sess_d;
   logic            tgt_q, tgt_d;
   logic [7:0]      cnt_lo_q, cnt_lo_d;
   logic [14:0]     remaining_q, remaining_d;
   logic [13:0]     index_q, index_d;
   logic [1:0]      k_q, k_d;
   logic [31:0]     word_q, word_d;
   logic [14:0]     adr_q, adr_d;
   logic [31:0]     dat_q, dat_d;
   logic            wen_q, wen_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic            tick, rx_fall, byte_valid, frame_err;
   logic [7:0]      rx_byte;
   logic [15:0]     word_cnt;

   assign tick     = (div_q == DivMax);
   assign rx_fall  = rx_prev_q & ~rx_s2_q;
   assign rx_byte  = shift_q;
   assign word_cnt = {rx_byte, cnt_lo_q};

   always_comb begin
      div_d      = tick ? '0 : div_q + DivW'(1);
      rx_st_d    = rx_st_q;
      tcnt_d     = tcnt_q;
      bcnt_d     = bcnt_q;
      shift_d    = shift_q;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      unique case (rx_st_q)
         RIdle: begin
            if (rx_fall) begin
               rx_st_d = RStart;
               tcnt_d  = 4'd0;
            end
         end
         RStart: begin
            if (tick) begin
               tcnt_d = tcnt_q + 4'd1;
               // Mid start bit: a high line here means the edge was a glitch
               if (tcnt_q == 4'd7) begin
                  tcnt_d  = 4'd0;
                  bcnt_d  = 3'd0;
                  rx_st_d = rx_s2_q ? RIdle : RData;
               end
            end
         end
         RData: begin
            if (tick) begin
               tcnt_d = tcnt_q + 4'd1;
               if (tcnt_q == 4'd15) begin
                  shift_d = {rx_s2_q, shift_q[7:1]};
                  bcnt_d  = bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) rx_st_d = RStop;
               end
            end
         end
         RStop: begin
            if (tick) begin
               tcnt_d = tcnt_q + 4'd1;
               if (tcnt_q == 4'd15) begin
                  rx_st_d    = RIdle;
                  byte_valid = rx_s2_q;
                  frame_err  = ~rx_s2_q;
               end
            end
         end
         default: rx_st_d = RIdle;
      endcase
   end

   always_comb begin
      sess_d      = sess_q;
      tgt_d       = tgt_q;
      cnt_lo_d    = cnt_lo_q;
      remaining_d = remaining_q;
      index_d     = index_q;
      k_d         = k_q;
      word_d      = word_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      wen_d       = 1'b0;
      done_d      = done_q;
      err_d       = err_q;
      if (start) begin
         sess_d      = SHdr0;
         err_d       = 1'b0;
         done_d      = 1'b0;
         k_d         = 2'd0;
         index_d     = 14'd0;
         remaining_d = 15'd0;
      end else begin
         unique case (sess_q)
            SHdr0: begin
               if (byte_valid) begin
                  if (rx_byte[7:1] == 7'd0) begin
                     tgt_d  = rx_byte[0];
                     sess_d = SHdr1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            SHdr1: begin
               if (byte_valid) begin
                  cnt_lo_d = rx_byte;
                  sess_d   = SHdr2;
               end
            end
            SHdr2: begin
               if (byte_valid) begin
                  if (word_cnt == 16'd0) begin
                     sess_d = SDone;
                     done_d = 1'b1;
                  end else if (word_cnt > 16'd16384) begin
                     err_d  = 1'b1;
                     sess_d = SHdr0;
                  end else begin
                     sess_d      = SData;
                     index_d     = 14'd0;
                     k_d         = 2'd0;
                     remaining_d = word_cnt[14:0];
                  end
               end
            end
            SData: begin
               // Bytes shift in from the top so byte 0 ends up in bits 7:0
               if (byte_valid) begin
                  word_d = {rx_byte, word_q[31:8]};
                  k_d    = k_q + 2'd1;
                  if (k_q == 2'd3) begin
                     sess_d = SWrite;
                     wen_d  = 1'b1;
                     adr_d  = {tgt_q, index_q};
                     dat_d  = {rx_byte, word_q[31:8]};
                  end
               end
            end
            SWrite: begin
               index_d     = index_q + 14'd1;
               remaining_d = remaining_q - 15'd1;
               if (remaining_q == 15'd1) begin
                  sess_d = SDone;
                  done_d = 1'b1;
               end else begin
                  sess_d = SData;
               end
            end
            SDone: ;
            default: sess_d = SHdr0;
         endcase
         // A completed load ignores the line entirely, including bad frames
         if (frame_err && sess_q != SDone) begin
            err_d  = 1'b1;
            sess_d = SHdr0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         div_q       <= '0;
         rx_st_q     <= RIdle;
         tcnt_q      <= 4'd0;
         bcnt_q      <= 3'd0;
         shift_q     <= 8'd0;
         sess_q      <= SHdr0;
         tgt_q       <= 1'b0;
         cnt_lo_q    <= 8'd0;
         remaining_q <= 15'd0;
         index_q     <= 14'd0;
         k_q         <= 2'd0;
         word_q      <= 32'd0;
         adr_q       <= 15'd0;
         dat_q       <= 32'd0;
         wen_q       <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         rx_s1_q     <= rx;
         rx_s2_q     <= rx_s1_q;
         rx_prev_q   <= rx_s2_q;
         div_q       <= div_d;
         rx_st_q     <= rx_st_d;
         tcnt_q      <= tcnt_d;
         bcnt_q      <= bcnt_d;
         shift_q     <= shift_d;
         sess_q      <= sess_d;
         tgt_q       <= tgt_d;
         cnt_lo_q    <= cnt_lo_d;
         remaining_q <= remaining_d;
         index_q     <= index_d;
         k_q         <= k_d;
         word_q      <= word_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         wen_q       <= wen_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign upg_wen_o  = wen_q;
   assign upg_adr_o  = adr_q;
   assign upg_dat_o  = dat_q;
   assign upg_done_o = done_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_uart_prog_rx.sv
// Bench for uart_prog_rx: serial stimulus at 64 clocks/bit, expected writes queued and
// compared by a negedge monitor as upg_wen_o pulses appear.
module tb_uart_prog_rx;

   localparam int unsigned BIT = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        rx = 1'b1;
   logic        upg_wen_o;
   logic [14:0] upg_adr_o;
   logic [31:0] upg_dat_o;
   logic        upg_done_o;
   logic        err_o;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          wen_cnt = 0;
   int          last_wen_cyc = -1;
   int          done_rise_cyc = -1;
   logic        wen_prev = 1'b0;
   logic        done_prev = 1'b0;
   logic [46:0] exp_q[$];

   uart_prog_rx #(
      .CLK_FREQ(6_400_000),
      .BAUD    (100_000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rx        (rx),
      .upg_wen_o (upg_wen_o),
      .upg_adr_o (upg_adr_o),
      .upg_dat_o (upg_dat_o),
      .upg_done_o(upg_done_o),
      .err_o     (err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Scoreboard: every write strobe must match the oldest queued expectation
   always @(negedge clk) begin
      logic [46:0] e;
      if (rst) begin
         if (upg_wen_o) begin
            wen_cnt++;
            last_wen_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_wen: got adr=%h dat=%h, required no write",
                        upg_adr_o, upg_dat_o);
            end else begin
               e = exp_q.pop_front();
               if ({upg_adr_o, upg_dat_o} !== e) begin
                  errors++;
                  $display("FAIL wen_data: got adr=%h dat=%h, required adr=%h dat=%h",
                           upg_adr_o, upg_dat_o, e[46:32], e[31:0]);
               end
            end
            checks++;
            if (wen_prev !== 1'b0) begin
               errors++;
               $display("FAIL wen_width: wen high for 2+ cycles, required 1-cycle pulse");
            end
         end
         if (upg_done_o && !done_prev) done_rise_cyc = cyc;
         wen_prev  = upg_wen_o;
         done_prev = upg_done_o;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(posedge clk);
      end
      rx = stop_bit;
      repeat (BIT) @(posedge clk);
      rx = 1'b1;
      if (!stop_bit) repeat (BIT) @(posedge clk);
   endtask

   // Bytes are listed most-significant first so literals read in wire order
   task automatic send_seq(input logic [95:0] v, input int n);
      for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], 1'b1);
   endtask

   task automatic pulse_start();
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      checks++;
      if (upg_done_o !== 1'b0) begin
         errors++;
         $display("FAIL start_done_fall: got done=%b, required 0", upg_done_o);
      end
      checks++;
      if (err_o !== 1'b0) begin
         errors++;
         $display("FAIL start_err_clear: got err=%b, required 0", err_o);
      end
   endtask

   task automatic test_reset();
      rx  = 1'b1;
      rst = 1'b0;
      step(3);
      checks++;
      if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o} !== 50'd0) begin
         errors++;
         $display("FAIL reset_outputs: got wen=%b adr=%h dat=%h done=%b err=%b, required all 0",
                  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o);
      end
      rst = 1'b1;
      step(4);
   endtask

   task automatic test_back_to_back();
      int w0;
      pulse_start();
      w0 = wen_cnt;
      exp_q.push_back({15'h4000, 32'h1234_5678});
      exp_q.push_back({15'h4001, 32'hDEAD_BEEF});
      send_seq(96'h010200_78563412_EFBEADDE, 11);
      step(4);
      checks++;
      if (wen_cnt - w0 !== 2) begin
         errors++;
         $display("FAIL b2b_wen_count: got %0d, required 2", wen_cnt - w0);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL b2b_pending: got %0d writes missing, required 0", exp_q.size());
      end
      checks++;
      if (upg_done_o !== 1'b1 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_status: got done=%b err=%b, required done=1 err=0", upg_done_o, err_o);
      end
      checks++;
      if (done_rise_cyc !== last_wen_cyc + 1) begin
         errors++;
         $display("FAIL b2b_done_timing: got done rise at cycle %0d, required %0d",
                  done_rise_cyc, last_wen_cyc + 1);
      end
   endtask

   task automatic test_zero_count();
      int w0;
      pulse_start();
      w0 = wen_cnt;
      send_seq(96'h000000, 3);
      step(4);
      checks++;
      if (upg_done_o !== 1'b1 || wen_cnt !== w0) begin
         errors++;
         $display("FAIL zero_count: got done=%b writes=%0d, required done=1 writes=0",
                  upg_done_o, wen_cnt - w0);
      end
   endtask

   task automatic test_bad_header();
      int w0;
      pulse_start();
      w0 = wen_cnt;
      send_seq(96'h07, 1);
      step(4);
      checks++;
      if (err_o !== 1'b1 || upg_done_o !== 1'b0 || wen_cnt !== w0) begin
         errors++;
         $display("FAIL bad_target: got err=%b done=%b writes=%0d, required err=1 done=0 writes=0",
                  err_o, upg_done_o, wen_cnt - w0);
      end
      exp_q.push_back({15'h0000, 32'hDDCC_BBAA});
      send_seq(96'h000100_AABBCCDD, 7);
      step(4);
      checks++;
      if (exp_q.size() !== 0 || wen_cnt - w0 !== 1 || upg_done_o !== 1'b1) begin
         errors++;
         $display("FAIL bad_hdr_recover: got pending=%0d writes=%0d done=%b, required 0 1 1",
                  exp_q.size(), wen_cnt - w0, upg_done_o);
      end
   endtask

   task automatic test_framing();
      int w0;
      pulse_start();
      w0 = wen_cnt;
      send_seq(96'h000100_AA, 4);
      send_byte(8'h55, 1'b0);
      step(4);
      checks++;
      if (err_o !== 1'b1 || wen_cnt !== w0) begin
         errors++;
         $display("FAIL framing_err: got err=%b writes=%0d, required err=1 writes=0",
                  err_o, wen_cnt - w0);
      end
      // Session must be back at the header: a fresh header plus one word loads cleanly
      exp_q.push_back({15'h4000, 32'h4433_2211});
      send_seq(96'h010100_11223344, 7);
      step(4);
      checks++;
      if (exp_q.size() !== 0 || wen_cnt - w0 !== 1 || err_o !== 1'b1) begin
         errors++;
         $display("FAIL framing_recover: got pending=%0d writes=%0d err=%b, required 0 1 1",
                  exp_q.size(), wen_cnt - w0, err_o);
      end
   endtask

   task automatic test_glitch();
      pulse_start();
      rx = 1'b0;
      step(4);
      rx = 1'b1;
      step(BIT * 12);
      checks++;
      if (err_o !== 1'b0) begin
         errors++;
         $display("FAIL glitch_err: got err=%b, required 0", err_o);
      end
      exp_q.push_back({15'h4000, 32'h0DF0_ADBA});
      send_seq(96'h010100_BAADF00D, 7);
      step(4);
      checks++;
      if (exp_q.size() !== 0 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL glitch_no_byte: got pending=%0d err=%b, required 0 0", exp_q.size(), err_o);
      end
   endtask

   task automatic test_restart();
      int w0;
      pulse_start();
      w0 = wen_cnt;
      send_seq(96'h000100_1122, 5);
      pulse_start();
      exp_q.push_back({15'h4000, 32'hD4C3_B2A1});
      send_seq(96'h010100_A1B2C3D4, 7);
      step(4);
      checks++;
      if (exp_q.size() !== 0 || wen_cnt - w0 !== 1) begin
         errors++;
         $display("FAIL restart: got pending=%0d writes=%0d, required 0 1",
                  exp_q.size(), wen_cnt - w0);
      end
   endtask

   task automatic test_async_reset();
      int w0;
      logic [7:0] b;
      w0 = wen_cnt;
      b  = 8'h5A;
      rx = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = b[i];
         repeat (BIT) @(posedge clk);
      end
      repeat (30) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checks++;
      if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o} !== 50'd0) begin
         errors++;
         $display("FAIL async_reset: got wen=%b adr=%h dat=%h done=%b err=%b, required all 0",
                  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o);
      end
      rx = 1'b1;
      step(5);
      rst = 1'b1;
      step(BIT * 12);
      checks++;
      if (wen_cnt !== w0 || upg_done_o !== 1'b0 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: got writes=%0d done=%b err=%b, required 0 0 0",
                  wen_cnt - w0, upg_done_o, err_o);
      end
   endtask

   task automatic test_count_limit();
      pulse_start();
      send_seq(96'h000140, 3);
      step(4);
      checks++;
      if (err_o !== 1'b1 || upg_done_o !== 1'b0) begin
         errors++;
         $display("FAIL count_over: got err=%b done=%b, required err=1 done=0", err_o, upg_done_o);
      end
      pulse_start();
      send_seq(96'h000040, 3);
      step(4);
      checks++;
      if (err_o !== 1'b0 || upg_done_o !== 1'b0) begin
         errors++;
         $display("FAIL count_max: got err=%b done=%b, required err=0 done=0", err_o, upg_done_o);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_zero_count();
      test_bad_header();
      test_framing();
      test_glitch();
      test_restart();
      test_async_reset();
      test_count_limit();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL final_pending: got %0d writes outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_prog_rx.md
# uart_prog_rx

UART programming receiver that feeds the instruction and data memories' upgrade (upg_*) write ports. It deserialises an 8N1 byte stream from the host, parses a 3-byte header (target memory, word count), and packs the payload into 32-bit little-endian words. Each word is written with a one-cycle `upg_wen_o` strobe at an auto-incrementing word address, and `upg_done_o` is raised when the load completes. It sits beside `cpu_top`'s memory block and drives `upg_wen_i` / `upg_adr_i` / `upg_dat_i` / `upg_done_i`.

## Interface
- `CLK_FREQ`, default 23_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate. Oversample divider `DIV = CLK_FREQ/(BAUD*16)`, integer, must be ≥ 1.
- `clk`, input, 1: single clock for all logic.
- `rst`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle pulse that (re)opens a programming session.
- `rx`, input, 1: serial line, idle high, asynchronous to `clk`.
- `upg_wen_o`, output, 1: one-cycle write strobe.
- `upg_adr_o`, output, 15: bit 14 is the target (0 = instruction, 1 = data); bits 13:0 are the word index.
- `upg_dat_o`, output, 32: write data.
- `upg_done_o`, output, 1: 1 means the load is complete and the CPU owns memory; 0 means programming is in progress.
- `err_o`, output, 1: sticky error flag, cleared by `start` or reset.

## Operation
- **RX front end**
  - `rx` passes through a 2-flop synchroniser.
  - A tick counter produces a 1-cycle `tick` every `DIV` clocks.
  - RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE → R_START on a synchronised falling edge.
  - In R_START, the line is re-sampled at tick 8. If it is high (glitch), return to R_IDLE; otherwise go to R_DATA.
  - Data: 8 bits, LSB first, each sampled at 16-tick intervals.
  - R_STOP samples the stop bit. If it is 1, emit an internal `byte_valid` pulse (1 cycle) with `byte`. If it is 0 (framing error), set `err_o`, discard the byte, and force the session FSM to S_HDR0.
- **Session FSM** (states S_HDR0, S_HDR1, S_HDR2, S_DATA, S_WRITE, S_DONE)
  - S_HDR0: target byte. 0x00 or 0x01 latches `tgt` and goes to S_HDR1. Any other value sets `err_o` and stays in S_HDR0.
  - S_HDR1 / S_HDR2: word count N, low byte then high byte (16 bits).
    - N = 0 → S_DONE with no writes.
    - N > 16384 → `err_o`, back to S_HDR0.
    - Otherwise → S_DATA with index = 0 and byte counter = 0.
  - S_DATA: byte k (k = 0..3) goes to `upg_dat_o[8k+7:8k]`. On k = 3 → S_WRITE.
  - S_WRITE (1 cycle): `upg_wen_o` = 1 with `upg_adr_o = {tgt, index}`.
    - Then index += 1 and remaining -= 1.
    - remaining = 0 → S_DONE; else → S_DATA.
  - S_DONE: `upg_done_o` = 1; further RX bytes are ignored.
  - `start` in any state: go to S_HDR0, clear `err_o`, `upg_done_o` = 0, clear byte/word counters. An RX byte completing in the same cycle is discarded.
- **Widths**: index is 14 bits and never wraps, because N ≤ 16384 is enforced.

## Timing
- Reset values: `upg_wen_o` = 0, `upg_adr_o` = 0, `upg_dat_o` = 0, `upg_done_o` = 0, `err_o` = 0. Both FSMs start in their idle states (R_IDLE, S_HDR0).
- `byte_valid` fires in the cycle of the stop-bit sample tick.
- `upg_wen_o` asserts exactly 1 cycle after the 4th byte's `byte_valid`.
- `upg_adr_o` and `upg_dat_o` are stable during `upg_wen_o` and are held until the next write.
- `upg_done_o` rises in the cycle after the last S_WRITE. It falls in the cycle after `start`.
- Byte-to-byte headroom is ≥ 16·DIV clocks, so S_WRITE never overlaps the next `byte_valid`.
- Asynchronous reset mid-frame or mid-session aborts immediately. No partial write is issued after reset.

## Test plan
All scenarios use CLK_FREQ = 6_400_000, BAUD = 100_000 (DIV = 4, 64 clocks/bit).
- **Normal data load**: after reset, send `start`, then bytes 01 02 00 | 78 56 34 12 | EF BE AD DE.
  - Two wen pulses: adr 0x4000 dat 0x12345678, then adr 0x4001 dat 0xDEADBEEF.
  - `upg_done_o` = 1 one cycle after the 2nd wen; `err_o` = 0.
- **Zero count**: send 00 00 00.
  - No wen; `upg_done_o` = 1 after the 3rd byte.
- **Invalid header**:
  - Bad target 0x07 → `err_o` = 1, no wen.
  - Then send 00 01 00 AA BB CC DD → wen with adr 0x0000 dat 0xDDCCBBAA.
- **Framing and glitch errors**:
  - A byte with stop bit 0 during S_DATA → `err_o` = 1, session back to S_HDR0, no wen.
  - A 1-tick low glitch on `rx` → no byte, no error.
- **Restart and reset**:
  - `start` after 2 payload bytes, then a full 1-word load → only 1 wen, at index 0.
  - `rst` low during a data bit → all outputs 0 immediately.
- **Count limit**: N = 0x4001 → `err_o` = 1.
